// File: rtl/mcu_el2_ifu_iccm_red_cam.sv
// ICCM redundant-row CAM: NUM_RED spare 39b words substituted into bank read data.
// Define MCU_ICCM_RED_STATS_EN to add per-entry saturating hit counters (red_hit_cnt).
module mcu_el2_ifu_iccm_red_cam #(
    parameter int unsigned ICCM_BITS    = 16,
    parameter int unsigned ICCM_BANK_HI = 3,
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned NUM_RED      = 4
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    iccm_wren,
    input  logic                    iccm_rden,
    input  logic [ICCM_BITS-1:1]    iccm_rw_addr,
    input  logic [2:0]              iccm_wr_size,
    input  logic [77:0]             iccm_wr_data,
    input  logic                    iccm_buf_correct_ecc,
    input  logic                    iccm_correction_state,
    input  logic                    red_flush,
    input  logic [NUM_BANKS*39-1:0] bank_dout,
    output logic [NUM_BANKS*39-1:0] bank_dout_fn,
    output logic [NUM_RED-1:0]      red_valid,
    output logic                    red_full,
    output logic                    red_hit
`ifdef MCU_ICCM_RED_STATS_EN
    ,
    output logic [NUM_RED*8-1:0]    red_hit_cnt
`endif
);

    localparam int unsigned AW = ICCM_BITS - 1;
    localparam int unsigned BW = ICCM_BANK_HI - 1;
    localparam int unsigned PW = $clog2(NUM_RED);

    logic                              dw;
    logic [ICCM_BITS-1:1]              addr_inc;
    logic                              unused_size;

    logic [NUM_RED-1:0]                valid_q, valid_d;
    logic [ICCM_BITS-1:2]              ra_q [NUM_RED];
    logic [ICCM_BITS-1:2]              ra_d [NUM_RED];
    logic [38:0]                       data_q [NUM_RED];
    logic [38:0]                       data_d [NUM_RED];
    logic [PW-1:0]                     ptr_q, ptr_d;
    logic [NUM_RED-1:0][NUM_BANKS-1:0] sel, sel_q, sel_d;

    logic [NUM_RED-1:0]                entry_hit;
    logic [NUM_RED-1:0]                dup_hit;
    logic [PW-1:0]                     hit_idx, dup_idx, inv_idx, victim;

    assign dw          = (iccm_wr_size[1:0] == 2'b11);
    assign addr_inc    = iccm_rw_addr + (dw ? AW'(2) : AW'(1));
    assign unused_size = iccm_wr_size[2];

    // A DW access can touch two words, so both the word and its successor are matched.
    always_comb begin
        for (int e = 0; e < NUM_RED; e++) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                sel[e][b] = valid_q[e] &
                    (((iccm_rw_addr[ICCM_BITS-1:2] == ra_q[e]) &
                      (iccm_rw_addr[ICCM_BANK_HI:2] == BW'(b))) |
                     ((addr_inc[ICCM_BITS-1:2] == ra_q[e]) &
                      (addr_inc[ICCM_BANK_HI:2] == BW'(b))));
            end
            entry_hit[e] = |sel[e];
            dup_hit[e]   = valid_q[e] & (ra_q[e] == iccm_rw_addr[ICCM_BITS-1:2]);
        end
    end

    assign red_hit = (iccm_rden | iccm_wren) & (|entry_hit);

    // Descending scans leave the lowest matching index in each result.
    always_comb begin
        hit_idx = '0;
        dup_idx = '0;
        inv_idx = '0;
        for (int e = NUM_RED - 1; e >= 0; e--) begin
            if (entry_hit[e]) hit_idx = PW'(e);
            if (dup_hit[e])   dup_idx = PW'(e);
            if (!valid_q[e])  inv_idx = PW'(e);
        end
        if (|dup_hit) begin
            victim = dup_idx;
        end else if (!(&valid_q)) begin
            victim = inv_idx;
        end else begin
            victim = ptr_q;
        end
    end

    always_comb begin
        valid_d = valid_q;
        ra_d    = ra_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        sel_d   = sel;
        for (int e = 0; e < NUM_RED; e++) begin
            if (valid_q[e] & iccm_wren &
                (iccm_rw_addr[ICCM_BITS-1:3] == ra_q[e][ICCM_BITS-1:3]) &
                ((iccm_rw_addr[2] == ra_q[e][2]) | dw)) begin
                data_d[e] = (ra_q[e][2] & (iccm_rw_addr[2] | dw)) ? iccm_wr_data[77:39]
                                                                  : iccm_wr_data[38:0];
            end
        end
        if (iccm_buf_correct_ecc) begin
            valid_d[victim] = 1'b1;
            ra_d[victim]    = iccm_rw_addr[ICCM_BITS-1:2];
            data_d[victim]  = iccm_wr_data[38:0];
            if (!(|dup_hit)) ptr_d = victim + PW'(1);
        end else if (iccm_rden & iccm_correction_state & (|entry_hit)) begin
            ptr_d = hit_idx + PW'(1);
        end
        if (red_flush) begin
            valid_d = '0;
            ptr_d   = '0;
            sel_d   = '0;
        end
    end

    always_comb begin
        bank_dout_fn = bank_dout;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int e = NUM_RED - 1; e >= 0; e--) begin
                if (sel_q[e][b]) bank_dout_fn[b*39 +: 39] = data_q[e];
            end
        end
        red_valid = valid_q;
        red_full  = &valid_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            valid_q <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            for (int e = 0; e < NUM_RED; e++) begin
                ra_q[e]   <= '0;
                data_q[e] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            ra_q    <= ra_d;
            data_q  <= data_d;
        end
    end

`ifdef MCU_ICCM_RED_STATS_EN
    logic [7:0] cnt_q [NUM_RED];
    logic [7:0] cnt_d [NUM_RED];

    always_comb begin
        for (int e = 0; e < NUM_RED; e++) begin
            cnt_d[e] = cnt_q[e];
            if (iccm_rden & entry_hit[e] & (cnt_q[e] != 8'hFF)) cnt_d[e] = cnt_q[e] + 8'd1;
            if (iccm_buf_correct_ecc & (victim == PW'(e)))     cnt_d[e] = '0;
            if (red_flush)                                      cnt_d[e] = '0;
            red_hit_cnt[e*8 +: 8] = cnt_q[e];
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int e = 0; e < NUM_RED; e++) cnt_q[e] <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_mcu_el2_ifu_iccm_red_cam.sv
// Self-checking bench for mcu_el2_ifu_iccm_red_cam: directed cases, then random traffic
// checked against a word-address reference model.
module tb_mcu_el2_ifu_iccm_red_cam;

    localparam int NR = 4;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          iccm_wren, iccm_rden;
    logic [15:1]   iccm_rw_addr;
    logic [2:0]    iccm_wr_size;
    logic [77:0]   iccm_wr_data;
    logic          iccm_buf_correct_ecc, iccm_correction_state, red_flush;
    logic [155:0]  bank_dout, bank_dout_fn;
    logic [3:0]    red_valid;
    logic          red_full, red_hit;
`ifdef MCU_ICCM_RED_STATS_EN
    logic [31:0]   red_hit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: entries keyed by 32-bit word index of the byte address.
    bit        m_valid [NR];
    int        m_word  [NR];
    bit [38:0] m_data  [NR];
    int        m_ptr;
    int        m_sel   [NB];
    int        m_cnt   [NR];

    always #5 clk = ~clk;

    mcu_el2_ifu_iccm_red_cam dut (
        .clk                   (clk),
        .rst_l                 (rst_l),
        .iccm_wren             (iccm_wren),
        .iccm_rden             (iccm_rden),
        .iccm_rw_addr          (iccm_rw_addr),
        .iccm_wr_size          (iccm_wr_size),
        .iccm_wr_data          (iccm_wr_data),
        .iccm_buf_correct_ecc  (iccm_buf_correct_ecc),
        .iccm_correction_state (iccm_correction_state),
        .red_flush             (red_flush),
        .bank_dout             (bank_dout),
        .bank_dout_fn          (bank_dout_fn),
        .red_valid             (red_valid),
        .red_full              (red_full),
        .red_hit               (red_hit)
`ifdef MCU_ICCM_RED_STATS_EN
        ,
        .red_hit_cnt           (red_hit_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [155:0] obs, input logic [155:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [155:0] rnd156();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[155:0];
    endfunction

    function automatic logic [77:0] rnd78();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[77:0];
    endfunction

    function automatic int cur_byte();
        return int'({iccm_rw_addr, 1'b0});
    endfunction

    function automatic bit is_dw();
        return iccm_wr_size[1:0] == 2'b11;
    endfunction

    // Does entry e cover bank b for the current access (first word or its successor)?
    function automatic bit ent_hit_bank(int e, int b);
        int w0, w1;
        w0 = cur_byte() / 4;
        w1 = ((cur_byte() + (is_dw() ? 4 : 2)) % 65536) / 4;
        return m_valid[e] && ((w0 == m_word[e] && w0 % 4 == b) || (w1 == m_word[e] && w1 % 4 == b));
    endfunction

    function automatic bit ent_hit(int e);
        bit h = 0;
        for (int b = 0; b < NB; b++) h |= ent_hit_bank(e, b);
        return h;
    endfunction

    task automatic model_reset();
        for (int e = 0; e < NR; e++) begin
            m_valid[e] = 0; m_word[e] = 0; m_data[e] = '0; m_cnt[e] = 0;
        end
        for (int b = 0; b < NB; b++) m_sel[b] = -1;
        m_ptr = 0;
    endtask

    task automatic model_update();
        bit        nv [NR];
        int        nw [NR];
        bit [38:0] nd [NR];
        int        nsel [NB];
        int        ncnt [NR];
        int        np, w0, victim, dup, inv, first_hit;
        w0 = cur_byte() / 4;
        np = m_ptr;
        dup = -1; inv = -1; first_hit = -1;
        for (int e = NR - 1; e >= 0; e--) begin
            nv[e] = m_valid[e]; nw[e] = m_word[e]; nd[e] = m_data[e]; ncnt[e] = m_cnt[e];
            if (m_valid[e] && m_word[e] == w0) dup = e;
            if (!m_valid[e]) inv = e;
            if (ent_hit(e)) first_hit = e;
        end
        for (int b = 0; b < NB; b++) begin
            nsel[b] = -1;
            for (int e = NR - 1; e >= 0; e--) if (ent_hit_bank(e, b)) nsel[b] = e;
        end
        for (int e = 0; e < NR; e++) begin
            if (m_valid[e] && iccm_wren && (w0 / 2 == m_word[e] / 2) &&
                ((w0 % 2 == m_word[e] % 2) || is_dw()))
                nd[e] = ((m_word[e] % 2 == 1) && ((w0 % 2 == 1) || is_dw())) ?
                        iccm_wr_data[77:39] : iccm_wr_data[38:0];
            if (iccm_rden && ent_hit(e) && m_cnt[e] < 255) ncnt[e] = m_cnt[e] + 1;
        end
        if (iccm_buf_correct_ecc) begin
            victim = (dup >= 0) ? dup : (inv >= 0) ? inv : m_ptr;
            nv[victim] = 1; nw[victim] = w0; nd[victim] = iccm_wr_data[38:0]; ncnt[victim] = 0;
            if (dup < 0) np = (victim + 1) % NR;
        end else if (iccm_rden && iccm_correction_state && first_hit >= 0) begin
            np = (first_hit + 1) % NR;
        end
        if (red_flush) begin
            for (int e = 0; e < NR; e++) begin nv[e] = 0; ncnt[e] = 0; end
            for (int b = 0; b < NB; b++) nsel[b] = -1;
            np = 0;
        end
        m_valid = nv; m_word = nw; m_data = nd; m_sel = nsel; m_cnt = ncnt; m_ptr = np;
    endtask

    task automatic check_model();
        logic [155:0] efn;
        logic [3:0]   ev;
        bit           ehit;
        logic [31:0]  ecnt;
        ehit = 0;
        for (int e = 0; e < NR; e++) begin
            ev[e] = m_valid[e];
            ehit |= ent_hit(e);
            ecnt[e*8 +: 8] = 8'(m_cnt[e]);
        end
        for (int b = 0; b < NB; b++)
            efn[b*39 +: 39] = (m_sel[b] >= 0) ? m_data[m_sel[b]] : bank_dout[b*39 +: 39];
        chk("red_valid", 156'(red_valid), 156'(ev));
        chk("red_full", 156'(red_full), 156'(&ev));
        chk("red_hit", 156'(red_hit), 156'(ehit && (iccm_rden || iccm_wren)));
        chk("bank_dout_fn", bank_dout_fn, efn);
`ifdef MCU_ICCM_RED_STATS_EN
        chk("red_hit_cnt", 156'(red_hit_cnt), 156'(ecnt));
`endif
    endtask

    // One clock: compare outputs mid-cycle, advance model, land 1 time unit past the edge.
    task automatic step();
        #1;
        check_model();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iccm_wren = 0; iccm_rden = 0; iccm_buf_correct_ecc = 0;
        iccm_correction_state = 0; red_flush = 0; iccm_wr_size = 3'b010;
    endtask

    task automatic set_addr(input int byte_addr);
        iccm_rw_addr = 15'(byte_addr / 2);
    endtask

    task automatic alloc(input int byte_addr, input logic [38:0] d);
        idle();
        set_addr(byte_addr);
        iccm_buf_correct_ecc = 1;
        iccm_wr_data = {39'h0, d};
        step();
        iccm_buf_correct_ecc = 0;
    endtask

    task automatic rd(input int byte_addr);
        idle();
        set_addr(byte_addr);
        iccm_rden = 1;
        bank_dout = rnd156();
        step();
        iccm_rden = 0;
    endtask

    task automatic flush();
        idle();
        red_flush = 1;
        step();
        red_flush = 0;
    endtask

    initial begin
        rst_l = 0;
        idle();
        iccm_rw_addr = '0;
        iccm_wr_data = '0;
        bank_dout = rnd156();
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_l = 1;
        @(posedge clk);
        #1;
        chk("reset_valid", 156'(red_valid), 156'(4'b0000));
        chk("reset_full", 156'(red_full), 156'(1'b0));
        chk("reset_fn", bank_dout_fn, bank_dout);

        // 1: read with empty CAM returns raw data
        rd(16'h0010);
        chk("t1_fn_raw", bank_dout_fn, bank_dout);

        // 2: single allocation substitutes bank1
        alloc(16'h0024, 39'h12345);
        chk("t2_valid", 156'(red_valid), 156'(4'b0001));
        rd(16'h0024);
        chk("t2_bank1", 156'(bank_dout_fn[77:39]), 156'(39'h12345));
        chk("t2_bank0_raw", 156'(bank_dout_fn[38:0]), 156'(bank_dout[38:0]));

        // 3: fill, round-robin replace, duplicate-free reallocation
        flush();
        alloc(16'h0004, 39'h11);
        alloc(16'h0008, 39'h22);
        alloc(16'h000C, 39'h33);
        alloc(16'h0010, 39'h44);
        chk("t3_full", 156'(red_full), 156'(1'b1));
        alloc(16'h0014, 39'h55);
        rd(16'h0004);
        chk("t3_evicted_raw", 156'(bank_dout_fn[77:39]), 156'(bank_dout[77:39]));
        rd(16'h0014);
        chk("t3_replaced", 156'(bank_dout_fn[77:39]), 156'(39'h55));
        alloc(16'h0008, 39'h66);
        chk("t3_nodup_valid", 156'(red_valid), 156'(4'b1111));
        rd(16'h0008);
        chk("t3_rewrite", 156'(bank_dout_fn[116:78]), 156'(39'h66));
        rd(16'h000C);
        chk("t3_keep", 156'(bank_dout_fn[155:117]), 156'(39'h33));
        alloc(16'h0018, 39'h77);
        rd(16'h0008);
        chk("t3_ptr_kept", 156'(bank_dout_fn[116:78]), 156'(bank_dout[116:78]));

        // 4: coherence writes
        flush();
        alloc(16'h0024, 39'h0AAAA);
        idle();
        set_addr(16'h0020);
        iccm_wren = 1; iccm_wr_size = 3'b011;
        iccm_wr_data = {39'h5A5A5A5A5, 39'h0F0F0F};
        step();
        rd(16'h0024);
        chk("t4_dw_hi", 156'(bank_dout_fn[77:39]), 156'(39'h5A5A5A5A5));
        idle();
        set_addr(16'h0020);
        iccm_wren = 1; iccm_wr_size = 3'b010;
        iccm_wr_data = {39'h1111, 39'h2222};
        step();
        rd(16'h0024);
        chk("t4_w_other", 156'(bank_dout_fn[77:39]), 156'(39'h5A5A5A5A5));

        // 5: flush beats same-cycle allocate
        idle();
        set_addr(16'h0030);
        iccm_buf_correct_ecc = 1; red_flush = 1;
        iccm_wr_data = {39'h0, 39'h7777};
        step();
        idle();
        chk("t5_valid", 156'(red_valid), 156'(4'b0000));
        rd(16'h0030);
        chk("t5_raw", bank_dout_fn, bank_dout);

`ifdef MCU_ICCM_RED_STATS_EN
        // 6: saturating hit counter
        flush();
        alloc(16'h0000, 39'h99);
        for (int i = 0; i < 300; i++) rd(16'h0000);
        chk("t6_sat", 156'(red_hit_cnt[7:0]), 156'(8'hFF));
        alloc(16'h0000, 39'h9A);
        chk("t6_clear", 156'(red_hit_cnt[7:0]), 156'(8'h00));
`endif

        // Random traffic, with one asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            idle();
            if ($urandom_range(0, 7) == 0) set_addr(32'hFFE0 + 2 * $urandom_range(0, 15));
            else set_addr(2 * $urandom_range(0, 31));
            iccm_wr_size          = 3'($urandom_range(0, 7));
            iccm_wr_data          = rnd78();
            bank_dout             = rnd156();
            iccm_buf_correct_ecc  = ($urandom_range(0, 5) == 0);
            iccm_wren             = ($urandom_range(0, 3) == 0);
            iccm_rden             = ($urandom_range(0, 1) == 0);
            iccm_correction_state = ($urandom_range(0, 2) == 0);
            red_flush             = ($urandom_range(0, 39) == 0);
            step();
            if (i == 300) begin
                rst_l = 0;
                #1;
                model_reset();
                chk("mid_reset_valid", 156'(red_valid), 156'(4'b0000));
                chk("mid_reset_fn", bank_dout_fn, bank_dout);
                #1 rst_l = 1;
            end
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
